// File: rtl/sum_list_sequencer_if.sv
// Control/status bundle between sum_list_sequencer (slave) and the board/datapath side (master).
// Handshake: start is a level request whose 0->1 edge launches a walk. busy is high from
// INIT until the walk ends. done stays high (with err for an aborted cyclic walk) until
// start is seen low on a tick edge. The sequencer then returns to IDLE and waits for a new rise.
interface sum_list_sequencer_if;
    logic       tick;
    logic       start;
    logic       next_zero;
    logic       ld_sum;
    logic       ld_next;
    logic       sum_sel;
    logic       next_sel;
    logic       a_sel;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] node_cnt;

    modport master (
        output tick, start, next_zero,
        input  ld_sum, ld_next, sum_sel, next_sel, a_sel, busy, done, err, node_cnt
    );

    modport slave (
        input  tick, start, next_zero,
        output ld_sum, ld_next, sum_sel, next_sel, a_sel, busy, done, err, node_cnt
    );
endinterface

// File: rtl/sum_list_sequencer.sv
// Tick-gated controller that walks a linked list through the sum/next datapath.
// Define SUM_LOOP_GUARD_EN to add the MAX_NODES limit and the ERR state for cyclic lists.
module sum_list_sequencer #(
    parameter int MAX_NODES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    sum_list_sequencer_if.slave  bus,
    output logic [2:0]           dbg_state
);

    if (MAX_NODES < 1 || MAX_NODES > 255) begin : g_bad_max_nodes
        $error("sum_list_sequencer: MAX_NODES must be in 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_RD_VAL = 3'd2,
        S_RD_PTR = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
`ifdef SUM_LOOP_GUARD_EN
        , S_ERR  = 3'd6
`endif
    } state_t;

`ifdef SUM_LOOP_GUARD_EN
    localparam logic [7:0] NODE_LIMIT = 8'(MAX_NODES);
`endif

    state_t     state_q, state_d;
    logic [7:0] node_cnt_q, node_cnt_d;
    logic       rise_flag_q, rise_flag_d;
    logic       start_prev_q, start_prev_d;
    logic       ld_sum_q, ld_sum_d;
    logic       ld_next_q, ld_next_d;
    logic       sum_sel_q, sum_sel_d;
    logic       next_sel_q, next_sel_d;
    logic       a_sel_q, a_sel_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       start_rise;

    always_comb begin
        state_d      = state_q;
        node_cnt_d   = node_cnt_q;
        start_prev_d = bus.start;
        start_rise   = bus.start & ~start_prev_q;
        // Edges seen mid-walk are dropped; only an idle/finished sequencer remembers one.
        rise_flag_d  = rise_flag_q | (start_rise & ~busy_q);

        if (bus.tick) begin
            case (state_q)
                S_IDLE: begin
                    if (rise_flag_q || start_rise) begin
                        state_d     = S_INIT;
                        node_cnt_d  = 8'd0;
                        rise_flag_d = 1'b0;
                    end
                end
                S_INIT: begin
                    state_d    = S_RD_VAL;
                    node_cnt_d = node_cnt_q + 8'd1;
                end
                S_RD_VAL: state_d = S_RD_PTR;
                S_RD_PTR: state_d = S_CHECK;
                S_CHECK: begin
                    if (bus.next_zero) begin
                        state_d = S_DONE;
`ifdef SUM_LOOP_GUARD_EN
                    end else if (node_cnt_q == NODE_LIMIT) begin
                        state_d = S_ERR;
`endif
                    end else begin
                        state_d    = S_RD_VAL;
                        node_cnt_d = node_cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    if (!bus.start) state_d = S_IDLE;
                end
`ifdef SUM_LOOP_GUARD_EN
                S_ERR: begin
                    if (!bus.start) state_d = S_IDLE;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are registered decodes of the state being entered.
        ld_sum_d   = (state_d == S_INIT) || (state_d == S_RD_VAL);
        ld_next_d  = (state_d == S_INIT) || (state_d == S_RD_PTR);
        sum_sel_d  = (state_d == S_RD_VAL);
        next_sel_d = (state_d == S_RD_PTR);
        a_sel_d    = (state_d == S_RD_PTR);
        busy_d     = (state_d == S_INIT) || (state_d == S_RD_VAL) ||
                     (state_d == S_RD_PTR) || (state_d == S_CHECK);
`ifdef SUM_LOOP_GUARD_EN
        err_d      = (state_d == S_ERR);
        done_d     = (state_d == S_DONE) || (state_d == S_ERR);
`else
        err_d      = 1'b0;
        done_d     = (state_d == S_DONE);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            node_cnt_q   <= 8'd0;
            rise_flag_q  <= 1'b0;
            // A start already high when reset releases must not count as a new request.
            start_prev_q <= 1'b1;
            ld_sum_q     <= 1'b0;
            ld_next_q    <= 1'b0;
            sum_sel_q    <= 1'b0;
            next_sel_q   <= 1'b0;
            a_sel_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            node_cnt_q   <= node_cnt_d;
            rise_flag_q  <= rise_flag_d;
            start_prev_q <= start_prev_d;
            ld_sum_q     <= ld_sum_d;
            ld_next_q    <= ld_next_d;
            sum_sel_q    <= sum_sel_d;
            next_sel_q   <= next_sel_d;
            a_sel_q      <= a_sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.ld_sum   = ld_sum_q;
    assign bus.ld_next  = ld_next_q;
    assign bus.sum_sel  = sum_sel_q;
    assign bus.next_sel = next_sel_q;
    assign bus.a_sel    = a_sel_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.node_cnt = node_cnt_q;
    assign dbg_state    = state_q;

endmodule
